// File: rtl/addsub_serial.sv
// Multi-cycle WIDTH-bit adder/subtractor that processes SLICE bits per clock.
// It uses valid/ready on both sides and holds the result and flags until consumed.
module addsub_serial #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryin,
    input  logic             subtract,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e            r_state;
    state_e            w_state_next;

    logic [WIDTH-1:0]  r_opa;
    logic [WIDTH-1:0]  r_opb;
    logic [WIDTH-1:0]  r_sum;
    logic              r_carry;
    logic              r_cout;
    logic              r_ovf;
    logic              r_zero;
    logic [IDXW-1:0]   r_idx;

    logic              w_accept;
    logic              w_last;
    logic [SLICE:0]    w_slice_full;
    logic [SLICE-1:0]  w_slice_sum;
    logic              w_slice_cout;
    logic              w_msb_cin;
    logic [WIDTH-1:0]  w_sum_next;

    assign w_accept = in_valid && (r_state == StIdle);
    assign w_last   = (r_idx == LAST_IDX);

    // Operands shift right each clock, so the active slice is always the low SLICE bits.
    assign w_slice_full = {1'b0, r_opa[SLICE-1:0]} + {1'b0, r_opb[SLICE-1:0]}
                        + {{SLICE{1'b0}}, r_carry};
    assign w_slice_sum  = w_slice_full[SLICE-1:0];
    assign w_slice_cout = w_slice_full[SLICE];
    assign w_msb_cin    = r_opa[SLICE-1] ^ r_opb[SLICE-1] ^ w_slice_sum[SLICE-1];

    for (genvar s = 0; s < NSLICE; s++) begin : g_sum_slice
        assign w_sum_next[s*SLICE +: SLICE] = (r_idx == IDXW'(s)) ? w_slice_sum
                                                                  : r_sum[s*SLICE +: SLICE];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (w_accept) w_state_next = StBusy;
            StBusy: if (w_last) w_state_next = StDone;
            StDone: if (out_ready) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (r_state)
            StIdle: in_ready = 1'b1;
            StDone: out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_opa   <= '0;
            r_opb   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
            r_idx   <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        // Subtract is A + ~B + ~borrow; carry out then means "no borrow".
                        r_opa   <= a;
                        r_opb   <= b ^ {WIDTH{subtract}};
                        r_carry <= carryin ^ subtract;
                        r_idx   <= '0;
                    end
                end
                StBusy: begin
                    r_opa   <= r_opa >> SLICE;
                    r_opb   <= r_opb >> SLICE;
                    r_carry <= w_slice_cout;
                    r_sum   <= w_sum_next;
                    if (w_last) begin
                        r_cout <= w_slice_cout;
                        r_ovf  <= w_msb_cin ^ w_slice_cout;
                        r_zero <= (w_sum_next == '0);
                    end else begin
                        r_idx <= r_idx + IDXW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum      = r_sum;
    assign carryout = r_cout;
    assign overflow = r_ovf;
    assign zero     = r_zero;

endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial: directed and random 8-bit ops plus exhaustive 4-bit sweeps,
// all checked against plain-arithmetic expectations.
module tb_addsub_serial;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;

    logic       in_valid8 = 1'b0;
    logic       in_ready8;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       cin8 = 1'b0;
    logic       sub8 = 1'b0;
    logic       out_valid8;
    logic       out_ready8 = 1'b0;
    logic [7:0] sum8;
    logic       cout8, ovf8, zero8;

    logic       iv4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       cin4 = 1'b0;
    logic       sub4 = 1'b0;
    logic       or4 = 1'b0;
    logic       ir_s1, ov_s1, cout_s1, ovf_s1, zero_s1;
    logic       ir_s4, ov_s4, cout_s4, ovf_s4, zero_s4;
    logic [3:0] sum_s1, sum_s4;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    addsub_serial #(.WIDTH(8), .SLICE(2)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .carryin(cin8), .subtract(sub8), .out_valid(out_valid8),
        .out_ready(out_ready8), .sum(sum8), .carryout(cout8), .overflow(ovf8), .zero(zero8)
    );

    addsub_serial #(.WIDTH(4), .SLICE(1)) u_dut4s1 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv4), .in_ready(ir_s1),
        .a(a4), .b(b4), .carryin(cin4), .subtract(sub4), .out_valid(ov_s1),
        .out_ready(or4), .sum(sum_s1), .carryout(cout_s1), .overflow(ovf_s1), .zero(zero_s1)
    );

    addsub_serial #(.WIDTH(4), .SLICE(4)) u_dut4s4 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv4), .in_ready(ir_s4),
        .a(a4), .b(b4), .carryin(cin4), .subtract(sub4), .out_valid(ov_s4),
        .out_ready(or4), .sum(sum_s4), .carryout(cout_s4), .overflow(ovf_s4), .zero(zero_s4)
    );

    // Reference: exact integer arithmetic, then reduce modulo 2^w and range-check signed.
    function automatic void model(input int w, input longint oa, input longint ob,
                                  input bit cin, input bit sub, output longint esum,
                                  output bit ecout, output bit eovf, output bit ezero);
        longint m, sa, sb, r, sr, c;
        m  = longint'(1) << w;
        c  = cin ? 1 : 0;
        sa = (oa >= m / 2) ? oa - m : oa;
        sb = (ob >= m / 2) ? ob - m : ob;
        if (sub) begin
            r     = oa - ob - c;
            sr    = sa - sb - c;
            ecout = (r >= 0);
        end else begin
            r     = oa + ob + c;
            sr    = sa + sb + c;
            ecout = (r >= m);
        end
        esum  = ((r % m) + m) % m;
        eovf  = (sr < -(m / 2)) || (sr >= m / 2);
        ezero = (esum == 0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full 8-bit transaction; lat is clocks from accept edge to out_valid (20 = timeout).
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input bit tc, input bit ts,
                        output logic [7:0] gs, output logic [2:0] gf, output int lat);
        int guard = 0;
        while (!in_ready8 && guard < 20) begin
            tick();
            guard++;
        end
        a8 = ta; b8 = tb; cin8 = tc; sub8 = ts;
        in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
        lat = 0;
        while (!out_valid8 && lat < 20) begin
            tick();
            lat++;
        end
        gs = sum8;
        gf = {cout8, ovf8, zero8};
        out_ready8 = 1'b1;
        tick();
        out_ready8 = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) tick();
        total_cnt++;
        if ({in_ready8, out_valid8} !== 2'b10) begin
            $display("FAIL reset_handshake: got %b expected 10", {in_ready8, out_valid8});
        end else pass_cnt++;
        total_cnt++;
        if ({sum8, cout8, ovf8, zero8} !== 11'h0) begin
            $display("FAIL reset_outputs: got %h expected 000", {sum8, cout8, ovf8, zero8});
        end else pass_cnt++;
        total_cnt++;
        if ({ir_s1, ov_s1, ir_s4, ov_s4} !== 4'b1010) begin
            $display("FAIL reset_4bit: got %b expected 1010", {ir_s1, ov_s1, ir_s4, ov_s4});
        end else pass_cnt++;
        reset_n = 1'b1;
        tick();
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        bit         c;
        bit         s;
        logic [7:0] es;
        logic [2:0] ef;
    } vec_t;

    task automatic test_directed();
        vec_t vecs[6];
        logic [7:0] gs;
        logic [2:0] gf;
        int lat;
        vecs[0] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 3'b010};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 3'b101};
        vecs[2] = '{8'h01, 8'h01, 1'b1, 1'b0, 8'h03, 3'b000};
        vecs[3] = '{8'h05, 8'h05, 1'b0, 1'b1, 8'h00, 3'b101};
        vecs[4] = '{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 3'b000};
        vecs[5] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 3'b110};
        for (int i = 0; i < 6; i++) begin
            run8(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].s, gs, gf, lat);
            total_cnt++;
            if ({gs, gf} !== {vecs[i].es, vecs[i].ef}) begin
                $display("FAIL directed[%0d]: got sum=%h cout/ovf/zero=%b expected sum=%h %b",
                         i, gs, gf, vecs[i].es, vecs[i].ef);
            end else pass_cnt++;
            total_cnt++;
            if (lat !== 4) begin
                $display("FAIL directed_latency[%0d]: got %0d expected 4", i, lat);
            end else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [7:0] ta, tb, gs;
        logic [2:0] gf;
        bit tc, ts, ec, eo, ez;
        longint es;
        int lat;
        for (int i = 0; i < 40; i++) begin
            ta = 8'($urandom); tb = 8'($urandom); tc = 1'($urandom); ts = 1'($urandom);
            model(8, longint'(ta), longint'(tb), tc, ts, es, ec, eo, ez);
            run8(ta, tb, tc, ts, gs, gf, lat);
            total_cnt++;
            if ({lat[4:0], gs, gf} !== {5'd4, es[7:0], ec, eo, ez}) begin
                $display("FAIL random[%0d] %h %s %h c%0d: got lat=%0d sum=%h f=%b exp sum=%h f=%b",
                         i, ta, ts ? "-" : "+", tb, tc, lat, gs, gf, es[7:0], {ec, eo, ez});
            end else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] gs;
        logic [2:0] gf;
        bit ec, eo, ez;
        longint es;
        int lat;
        model(8, 64'h3C, 64'h5A, 1'b1, 1'b1, es, ec, eo, ez);
        a8 = 8'h3C; b8 = 8'h5A; cin8 = 1'b1; sub8 = 1'b1;
        in_valid8 = 1'b1;
        tick();
        lat = 0;
        while (!out_valid8 && lat < 20) begin
            a8 = 8'($urandom); b8 = 8'($urandom);
            tick();
            lat++;
        end
        gs = sum8;
        gf = {cout8, ovf8, zero8};
        total_cnt++;
        if ({lat[4:0], gs, gf} !== {5'd4, es[7:0], ec, eo, ez}) begin
            $display("FAIL bp_first: got lat=%0d sum=%h f=%b expected lat=4 sum=%h f=%b",
                     lat, gs, gf, es[7:0], {ec, eo, ez});
        end else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
            tick();
            total_cnt++;
            if ({out_valid8, in_ready8, sum8, cout8, ovf8, zero8} !== {2'b10, es[7:0], ec, eo, ez})
            begin
                $display("FAIL bp_hold[%0d]: got v/r=%b sum=%h f=%b expected 10 sum=%h f=%b", i,
                         {out_valid8, in_ready8}, sum8, {cout8, ovf8, zero8}, es[7:0],
                         {ec, eo, ez});
            end else pass_cnt++;
        end
        a8 = 8'hC8; b8 = 8'h64; cin8 = 1'b0; sub8 = 1'b0;
        model(8, 64'hC8, 64'h64, 1'b0, 1'b0, es, ec, eo, ez);
        out_ready8 = 1'b1;
        tick();
        out_ready8 = 1'b0;
        total_cnt++;
        if ({out_valid8, in_ready8} !== 2'b01) begin
            $display("FAIL bp_release: got v/r=%b expected 01", {out_valid8, in_ready8});
        end else pass_cnt++;
        tick();
        in_valid8 = 1'b0;
        lat = 0;
        while (!out_valid8 && lat < 20) begin
            tick();
            lat++;
        end
        total_cnt++;
        if ({lat[4:0], sum8, cout8, ovf8, zero8} !== {5'd4, es[7:0], ec, eo, ez}) begin
            $display("FAIL bp_second: got lat=%0d sum=%h f=%b expected lat=4 sum=%h f=%b",
                     lat, sum8, {cout8, ovf8, zero8}, es[7:0], {ec, eo, ez});
        end else pass_cnt++;
        out_ready8 = 1'b1;
        tick();
        out_ready8 = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [7:0] gs;
        logic [2:0] gf;
        int lat;
        a8 = 8'h55; b8 = 8'h22; cin8 = 1'b0; sub8 = 1'b0;
        in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        repeat (2) tick();
        reset_n = 1'b0;
        #1;
        total_cnt++;
        if ({in_ready8, out_valid8, sum8} !== {2'b10, 8'h00}) begin
            $display("FAIL reset_mid: got r/v=%b sum=%h expected 10 sum=00",
                     {in_ready8, out_valid8}, sum8);
        end else pass_cnt++;
        tick();
        reset_n = 1'b1;
        tick();
        run8(8'h03, 8'h04, 1'b0, 1'b0, gs, gf, lat);
        total_cnt++;
        if ({lat[4:0], gs, gf} !== {5'd4, 8'h07, 3'b000}) begin
            $display("FAIL after_reset: got lat=%0d sum=%h f=%b expected lat=4 sum=07 f=000",
                     lat, gs, gf);
        end else pass_cnt++;
    endtask

    task automatic test_exhaustive4();
        bit ec, eo, ez;
        longint es;
        int lat1, lat4;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    for (int is = 0; is < 2; is++) begin
                        a4 = 4'(ia); b4 = 4'(ib); cin4 = 1'(ic); sub4 = 1'(is);
                        model(4, longint'(ia), longint'(ib), 1'(ic), 1'(is), es, ec, eo, ez);
                        iv4 = 1'b1;
                        tick();
                        iv4 = 1'b0;
                        lat1 = -1;
                        lat4 = -1;
                        for (int c = 1; c <= 12 && (lat1 < 0 || lat4 < 0); c++) begin
                            tick();
                            if (lat1 < 0 && ov_s1) lat1 = c;
                            if (lat4 < 0 && ov_s4) lat4 = c;
                        end
                        total_cnt++;
                        if ({lat1[3:0], cout_s1, ovf_s1, zero_s1, sum_s1} !==
                            {4'd4, ec, eo, ez, es[3:0]}) begin
                            $display("FAIL exh_s1 %h %s %h c%0d: got lat=%0d sum=%h f=%b exp %h %b",
                                     ia, is ? "-" : "+", ib, ic, lat1, sum_s1,
                                     {cout_s1, ovf_s1, zero_s1}, es[3:0], {ec, eo, ez});
                        end else pass_cnt++;
                        total_cnt++;
                        if ({lat4[3:0], cout_s4, ovf_s4, zero_s4, sum_s4} !==
                            {4'd1, ec, eo, ez, es[3:0]}) begin
                            $display("FAIL exh_s4 %h %s %h c%0d: got lat=%0d sum=%h f=%b exp %h %b",
                                     ia, is ? "-" : "+", ib, ic, lat4, sum_s4,
                                     {cout_s4, ovf_s4, zero_s4}, es[3:0], {ec, eo, ez});
                        end else pass_cnt++;
                        or4 = 1'b1;
                        tick();
                        or4 = 1'b0;
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_exhaustive4();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
